data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory interface (daddr/dwdata/dwe in, drdata out) for the single-cycle core.
- Provides byte-enabled word RAM plus a small MMIO window:
  - console TX FIFO with valid/ready drain port,
  - free-running cycle counter,
  - status/overflow register.
- Reads are combinational so a load completes in the CPU's single cycle. Writes commit on the rising clock edge.

---
 rtl/data_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder side of the single-cycle core's data-memory interface.
//   Holds a byte-enabled word RAM plus an MMIO window that contains a
//   console TX FIFO, a free-running cycle counter and a status register.
//   Reads are combinational so a load finishes in the CPU's single cycle.
//   Writes commit on the rising edge of clk.
//
// Ports
//   clk            clock; all state updates on the rising edge
//   reset          asynchronous, active-low reset
//   daddr[31:0]    byte address from the CPU (bits [1:0] ignored)
//   dwdata[31:0]   lane-aligned write data
//   dwe[3:0]       byte-lane write enables
//   drdata[31:0]   read data for the word containing daddr
//   console_valid  console FIFO non-empty
//   console_data   console FIFO head byte (0 when empty)
//   console_ready  sink accepts the head byte this cycle
//
// MMIO map (word offsets from MMIO_BASE)
//   0x0 TXDATA  write pushes dwdata[7:0]; reads 0
//   0x4 STATUS  {28'b0, overflow, full, empty, valid}; write bit3=1 clears overflow
//   0x8 CYCLE   cycle counter; full-word write loads it
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FULL_COUNT = (FW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Address decode (word granularity)
  // ---------------------------------------------------------------------
  logic          is_mmio;
  logic [29:0]   mmio_word;
  logic [AW-1:0] ram_idx;
  logic          sel_tx;
  logic          sel_status;
  logic          sel_cycle;
  logic          unused_addr_bits;

  // The CPU extracts bytes itself, so the byte offset inside a word is unused.
  assign unused_addr_bits = ^daddr[1:0];

  assign is_mmio    = (daddr[31:2] >= MMIO_BASE[31:2]);
  assign mmio_word  = daddr[31:2] - MMIO_BASE[31:2];
  assign ram_idx    = daddr[AW+1:2];
  assign sel_tx     = is_mmio && (mmio_word == 30'd0);
  assign sel_status = is_mmio && (mmio_word == 30'd1);
  assign sel_cycle  = is_mmio && (mmio_word == 30'd2);

  // ---------------------------------------------------------------------
  // RAM: one byte-wide array per lane so each lane enable maps to its own
  // write port; upper address bits are dropped, giving natural aliasing.
  // ---------------------------------------------------------------------
  logic [31:0] ram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (reset && !is_mmio && dwe[gi]) begin
          lane_mem[ram_idx] <= dwdata[8*gi +: 8];
        end
      end

      assign ram_rdata[8*gi +: 8] = lane_mem[ram_idx];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Console FIFO, status and cycle counter state
  // ---------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [FW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [FW:0]   count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic [31:0]   cycle_reg, cycle_next;

  logic fifo_full;
  logic fifo_empty;
  logic push_req;
  logic push_ok;
  logic pop;

  assign fifo_full     = (count_reg == FULL_COUNT);
  assign fifo_empty    = (count_reg == '0);
  assign console_valid = !fifo_empty;
  assign console_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];

  // A push into a full FIFO still succeeds when the head leaves the same cycle.
  assign pop      = console_valid && console_ready;
  assign push_req = reset && sel_tx && dwe[0];
  assign push_ok  = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= dwdata[7:0];
    end
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    cycle_next    = cycle_reg + 32'd1;

    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + FW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + FW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + (FW+1)'(1);
      2'b01:   count_next = count_reg - (FW+1)'(1);
      default: count_next = count_reg;
    endcase

    if (push_req && !push_ok) begin
      overflow_next = 1'b1;
    end else if (sel_status && dwe[0] && dwdata[3]) begin
      overflow_next = 1'b0;
    end

    // A load takes priority over the increment; partial writes do nothing.
    if (sel_cycle && (dwe == 4'b1111)) begin
      cycle_next = dwdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      cycle_reg    <= 32'd0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      cycle_reg    <= cycle_next;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  always_comb begin
    drdata = ram_rdata;
    if (is_mmio) begin
      drdata = 32'd0;
      if (sel_status) begin
        drdata = {28'd0, overflow_reg, fifo_full, fifo_empty, console_valid};
      end else if (sel_cycle) begin
        drdata = cycle_reg;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder.
// Stimulus pushes expected read data and expected console bytes into
// queues; a negedge monitor pops and compares whenever a read check is
// flagged or the console port completes a handshake.
module tb_data_mem_responder;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;

  logic        rd_chk;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [7:0]  cons_q [$];

  int n_checks;
  int n_fail;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE  (32'h8000_0000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .daddr        (daddr),
    .dwdata       (dwdata),
    .dwe          (dwe),
    .drdata       (drdata),
    .console_valid(console_valid),
    .console_data (console_data),
    .console_ready(console_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares away from the active edge.
  always @(negedge clk) begin
    if (rd_chk) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd:unexpected got %h want <none>", drdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (drdata !== e) begin
          n_fail++;
          $display("FAIL rd:%s addr %h got %h want %h", n, daddr, drdata, e);
        end else begin
          $display("read  %-16s addr %h data %h", n, daddr, drdata);
        end
      end
    end
    if (console_valid === 1'b1 && console_ready === 1'b1) begin
      n_checks++;
      if (cons_q.size() == 0) begin
        n_fail++;
        $display("FAIL console:unexpected got %h want <none>", console_data);
      end else begin
        logic [7:0] b;
        b = cons_q.pop_front();
        if (console_data !== b) begin
          n_fail++;
          $display("FAIL console:byte got %h want %h", console_data, b);
        end else begin
          $display("pop   console byte %h", console_data);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end else begin
      $display("check %-16s %h", n, act);
    end
  endtask

  // Each task occupies one clock cycle, entered and left at posedge+1.
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    daddr  = a;
    dwe    = 4'b0000;
    exp_q.push_back(e);
    name_q.push_back(n);
    rd_chk = 1'b1;
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr  = a;
    dwdata = d;
    dwe    = we;
    $display("write addr %h data %h dwe %b", a, d, we);
    @(posedge clk);
    #1;
    dwe = 4'b0000;
  endtask

  task automatic push(input logic [7:0] b, input logic accepted);
    if (accepted) cons_q.push_back(b);
    wr(A_TX, {24'd0, b}, 4'b0001);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    daddr         = 32'd0;
    dwdata        = 32'd0;
    dwe           = 4'b0000;
    console_ready = 1'b0;
    rd_chk        = 1'b0;

    @(posedge clk);
    #1;
    // Reset state
    chk("rst_valid", {31'd0, console_valid}, 32'd0);
    chk("rst_cdata", {24'd0, console_data}, 32'd0);
    rd(A_ST,  32'h0000_0002, "rst_status");
    rd(A_CYC, 32'h0000_0000, "rst_cycle");
    reset = 1'b1;

    // Byte-lane writes and aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "sw_word");
    wr(32'h0000_0010, 32'h00AA_0000, 4'b0100);
    rd(32'h0000_0010, 32'hDEAA_BEEF, "byte_lane2");
    rd(32'h0000_1010, 32'hDEAA_BEEF, "alias_1010");
    rd(32'h0000_2010, 32'hDEAA_BEEF, "alias_2010");
    rd(32'h0000_0013, 32'hDEAA_BEEF, "low_bits_ign");

    // Fill FIFO with sink stalled; status = full|valid
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i), 1'b1);
    rd(A_ST, 32'h0000_0005, "st_full");
    rd(A_TX, 32'h0000_0000, "txdata_rd0");
    rd(32'h8000_000C, 32'h0000_0000, "mmio_hole");
    push(8'h49, 1'b0);
    rd(A_ST, 32'h0000_000D, "st_overflow");
    wr(A_ST, 32'h0000_0008, 4'b0001);
    rd(A_ST, 32'h0000_0005, "st_ovf_clr");

    // Push into full FIFO while the head drains: no overflow, stays full
    console_ready = 1'b1;
    push(8'h50, 1'b1);
    console_ready = 1'b0;
    rd(A_ST, 32'h0000_0005, "st_pushpop");

    // Drain 0x42..0x48 then 0x50, one per cycle
    console_ready = 1'b1;
    for (int i = 0; i < 20 && console_valid; i++) begin
      @(posedge clk);
      #1;
    end
    console_ready = 1'b0;
    chk("drain_valid", {31'd0, console_valid}, 32'd0);
    chk("drain_cdata", {24'd0, console_data}, 32'd0);
    chk("drain_left", cons_q.size(), 32'd0);
    rd(A_ST, 32'h0000_0002, "st_empty");

    // Cycle counter load, wrap, partial write ignored
    wr(A_CYC, 32'hFFFF_FFFE, 4'b1111);
    rd(A_CYC, 32'hFFFF_FFFE, "cyc_loaded");
    rd(A_CYC, 32'hFFFF_FFFF, "cyc_plus1");
    rd(A_CYC, 32'h0000_0000, "cyc_wrap");
    wr(A_CYC, 32'h1234_5678, 4'b0011);
    rd(A_CYC, 32'h0000_0002, "cyc_partial");

    // Asynchronous reset with 3 bytes queued
    push(8'h61, 1'b1);
    push(8'h62, 1'b1);
    push(8'h63, 1'b1);
    chk("pre_rst_valid", {31'd0, console_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, console_valid}, 32'd0);
    chk("arst_cdata", {24'd0, console_data}, 32'd0);
    cons_q.delete();
    @(posedge clk);
    #1;
    rd(A_ST,  32'h0000_0002, "arst_status");
    rd(A_CYC, 32'h0000_0000, "arst_cycle");
    wr(32'h0000_0010, 32'h1111_1111, 4'b1111);
    push(8'h70, 1'b0);
    rd(32'h0000_0010, 32'hDEAA_BEEF, "ram_in_rst");
    reset = 1'b1;
    rd(A_ST, 32'h0000_0002, "post_rst_st");
    rd(32'h0000_0010, 32'hDEAA_BEEF, "ram_post_rst");

    @(posedge clk);
    #1;
    chk("rd_q_left", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
